// File: rtl/stq_pkg.sv
// Shared types, default parameters and width helpers for the store queue.
// Configuration macro used by the top: STORE_QUEUE_MERGE_EN.
package stq_pkg;

    localparam int STQ_DEPTH    = 8;
    localparam int STQ_AW       = 16;
    localparam int STQ_DW       = 16;
    localparam int STQ_COMMIT_W = 2;

    typedef struct packed {
        logic              valid;
        logic [STQ_AW-1:0] addr;
        logic [STQ_DW-1:0] data;
    } stq_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/store_queue_chk.sv
// Protocol checker for the store queue: commits may never exceed the
// number of speculative entries currently held.
module store_queue_chk #(
    parameter int CW = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] commit_req_i,
    input logic [CW-1:0] spec_cnt_i
);

    a_commit_le_spec: assert property (@(posedge clk) disable iff (!rst_n)
        commit_req_i <= spec_cnt_i);

endmodule

// File: rtl/stq_fwd_match.sv
// Age-ordered store-to-load forwarding matcher: youngest valid entry whose
// address equals the search address wins; miss returns zero data.
module stq_fwd_match
    import stq_pkg::*;
#(
    parameter int DEPTH = STQ_DEPTH,
    parameter int AW    = STQ_AW,
    parameter int DW    = STQ_DW,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic [DEPTH-1:0]    valid_i,
    input  logic [DEPTH*AW-1:0] addr_i,
    input  logic [DEPTH*DW-1:0] data_i,
    input  logic [PW-1:0]       head_i,
    input  logic [AW-1:0]       search_addr_i,
    output logic                hit_o,
    output logic [DW-1:0]       data_o
);

    // Walk oldest to youngest from head so later (younger) matches override.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PW-1:0] idx;
            idx = head_i + PW'(k);
            if (valid_i[idx] && (addr_i[idx*AW +: AW] == search_addr_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[idx*DW +: DW];
            end else begin
                data_o = data_o;
            end
        end
    end

endmodule

// File: rtl/store_queue.sv
// Circular store queue: speculative region (cmt..tail), committed region (head..cmt).
// `define STORE_QUEUE_MERGE_EN to coalesce same-address enqueues into the youngest speculative entry.
module store_queue
    import stq_pkg::*;
#(
    parameter int DEPTH    = STQ_DEPTH,
    parameter int AW       = STQ_AW,
    parameter int DW       = STQ_DW,
    parameter int COMMIT_W = STQ_COMMIT_W,
    localparam int PW      = ptr_w(DEPTH),
    localparam int CW      = cnt_w(DEPTH),
    localparam int KW      = cnt_w(COMMIT_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          enq_valid,
    input  logic [AW-1:0] enq_addr,
    input  logic [DW-1:0] enq_data,
    output logic          enq_ready,
    input  logic [KW-1:0] commit_cnt,
    input  logic [AW-1:0] search_addr,
    output logic          search_hit,
    output logic [DW-1:0] search_data,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [PW-1:0]       head_q, cmt_q, tail_q, head_d, cmt_d, tail_d;
    logic [CW-1:0]       count_q, ncmt_q, count_d, ncmt_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH*AW-1:0] addr_q;
    logic [DEPTH*DW-1:0] data_q;

    logic [CW-1:0] spec_cnt_s, commit_req_s, cmt_amt_s;
    logic [PW-1:0] youngest_s;
    logic          pop_s, merge_s, enq_fire_s;

    // Entry count, committed count and clamped commit amount.
    always_comb begin
        spec_cnt_s   = count_q - ncmt_q;
        commit_req_s = CW'(commit_cnt);
        cmt_amt_s    = (commit_req_s > spec_cnt_s) ? spec_cnt_s : commit_req_s;
        youngest_s   = tail_q - PW'(1);
        enq_ready    = (count_q != CW'(DEPTH));
        empty        = (count_q == '0);
        count        = count_q;
        mem_valid    = (ncmt_q != '0);
        mem_addr     = mem_valid ? addr_q[head_q*AW +: AW] : '0;
        mem_data     = mem_valid ? data_q[head_q*DW +: DW] : '0;
        pop_s        = mem_valid && mem_ready;
`ifdef STORE_QUEUE_MERGE_EN
        // The youngest entry must still be speculative after this cycle's commit.
        merge_s      = enq_valid && enq_ready && !flush && (spec_cnt_s > cmt_amt_s) &&
                       (addr_q[youngest_s*AW +: AW] == enq_addr);
`else
        merge_s      = 1'b0;
`endif
        enq_fire_s   = enq_valid && enq_ready && !flush && !merge_s;
    end

    // Next-state pointers, counts and valid bits.
    always_comb begin
        head_d = head_q + PW'(pop_s);
        cmt_d  = cmt_q + PW'(cmt_amt_s);
        ncmt_d = ncmt_q + cmt_amt_s - CW'(pop_s);
        if (flush) begin
            tail_d  = cmt_d;
            count_d = ncmt_d;
        end else begin
            tail_d  = tail_q + PW'(enq_fire_s);
            count_d = count_q + CW'(enq_fire_s) - CW'(pop_s);
        end
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] rel;
            rel = PW'(i) - head_q;
            if (pop_s && (PW'(i) == head_q)) begin
                valid_d[i] = 1'b0;
            end else if (flush && (CW'(rel) >= (ncmt_q + cmt_amt_s))) begin
                valid_d[i] = 1'b0;
            end else if (enq_fire_s && (PW'(i) == tail_q)) begin
                valid_d[i] = 1'b1;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ncmt_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ncmt_q  <= ncmt_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (enq_fire_s) begin
            addr_q[tail_q*AW +: AW] <= enq_addr;
            data_q[tail_q*DW +: DW] <= enq_data;
        end else if (merge_s) begin
            data_q[youngest_s*DW +: DW] <= enq_data;
        end else begin
            addr_q <= addr_q;
        end
    end

    stq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
        .valid_i      (valid_q),
        .addr_i       (addr_q),
        .data_i       (data_q),
        .head_i       (head_q),
        .search_addr_i(search_addr),
        .hit_o        (search_hit),
        .data_o       (search_data)
    );

    store_queue_chk #(.CW(CW)) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit_req_i(commit_req_s),
        .spec_cnt_i  (spec_cnt_s)
    );

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_store_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic [15:0] enq_addr = 16'h0;
    logic [15:0] enq_data = 16'h0;
    logic        enq_ready;
    logic [1:0]  commit_cnt = 2'd0;
    logic [15:0] search_addr = 16'h0;
    logic        search_hit;
    logic [15:0] search_data;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [3:0]  count;
    logic        empty;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_addr[$];
    logic [15:0] m_data[$];
    int          m_ncmt = 0;

    store_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_ready(enq_ready),
        .commit_cnt(commit_cnt), .search_addr(search_addr),
        .search_hit(search_hit), .search_data(search_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int legal_cc(input int want);
        int spec;
        spec = m_addr.size() - m_ncmt;
        if (want > spec) return spec;
        return (want > 2) ? 2 : want;
    endfunction

    task automatic check_outputs();
        int          sz;
        logic        hit;
        logic [15:0] d;
        sz  = m_addr.size();
        hit = 1'b0;
        d   = 16'h0;
        for (int i = 0; i < sz; i++) begin
            if (m_addr[i] == search_addr) begin
                hit = 1'b1;
                d   = m_data[i];
            end
        end
        chk("enq_ready", 32'(enq_ready), 32'(sz < 8));
        chk("count", 32'(count), 32'(sz));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("mem_valid", 32'(mem_valid), 32'(m_ncmt > 0));
        if (m_ncmt > 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_addr[0]));
            chk("mem_data", 32'(mem_data), 32'(m_data[0]));
        end
        chk("search_hit", 32'(search_hit), 32'(hit));
        chk("search_data", 32'(search_data), 32'(d));
    endtask

    task automatic model_update(input logic ev, input logic [15:0] ea, input logic [15:0] ed,
                                input int cc, input logic fl, input logic mr);
        int spec, amt, old_sz;
        bit mv;
        old_sz = m_addr.size();
        spec   = old_sz - m_ncmt;
        amt    = (cc > spec) ? spec : cc;
        mv     = (m_ncmt > 0);
        m_ncmt += amt;
        if (mv && mr) begin
            void'(m_addr.pop_front());
            void'(m_data.pop_front());
            m_ncmt--;
        end
        if (fl) begin
            while (m_addr.size() > m_ncmt) begin
                void'(m_addr.pop_back());
                void'(m_data.pop_back());
            end
        end else if (ev && old_sz < 8) begin
`ifdef STORE_QUEUE_MERGE_EN
            if (spec > amt && m_addr[m_addr.size()-1] == ea) begin
                m_data[m_data.size()-1] = ed;
            end else begin
                m_addr.push_back(ea);
                m_data.push_back(ed);
            end
`else
            m_addr.push_back(ea);
            m_data.push_back(ed);
`endif
        end
    endtask

    task automatic step(input logic ev, input logic [15:0] ea, input logic [15:0] ed,
                        input int cc, input logic fl, input logic mr, input logic [15:0] sa);
        @(negedge clk);
        enq_valid   = ev;
        enq_addr    = ea;
        enq_data    = ed;
        commit_cnt  = cc[1:0];
        flush       = fl;
        mem_ready   = mr;
        search_addr = sa;
        #1;
        check_outputs();
        @(posedge clk);
        model_update(ev, ea, ed, cc, fl, mr);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_data"}, 32'(mem_data), 32'd0);
        chk({tag, "_search_hit"}, 32'(search_hit), 32'd0);
        chk({tag, "_search_data"}, 32'(search_data), 32'd0);
    endtask

    initial begin
        logic [15:0] sa;
        int          cc;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: two enqueues, forward the younger one
        step(1'b1, 16'h0010, 16'h1111, 0, 1'b0, 1'b0, 16'h0020);
        step(1'b1, 16'h0020, 16'h2222, 0, 1'b0, 1'b0, 16'h0020);
        step(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 16'h0020);
        step(1'b0, 16'h0000, 16'h0000, 2, 1'b0, 1'b1, 16'h0010);
        repeat (3) step(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, 16'h0010);

        // 2: same address twice, youngest forwarded, ordered drain
        step(1'b1, 16'h0010, 16'hAAAA, 0, 1'b0, 1'b0, 16'h0010);
        step(1'b1, 16'h0010, 16'hBBBB, 0, 1'b0, 1'b0, 16'h0010);
        step(1'b0, 16'h0000, 16'h0000, 2, 1'b0, 1'b1, 16'h0010);
        repeat (3) step(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, 16'h0010);

        // 3: fill to full, overflow dropped, one pop re-opens
        for (int i = 0; i < 9; i++)
            step(1'b1, 16'(16'h0100 + i), 16'(16'hC000 + i), 0, 1'b0, 1'b0, 16'h0103);
        step(1'b1, 16'h0200, 16'hDEAD, 1, 1'b0, 1'b0, 16'h0200);
        step(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, 16'h0107);
        step(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 16'h0100);
        step(1'b0, 16'h0000, 16'h0000, legal_cc(2), 1'b1, 1'b0, 16'h0100);
        repeat (3) step(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, 16'h0100);

        // 4: five entries, commit two with flush in the same cycle
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'(16'h0300 + i), 16'(16'hE000 + i), 0, 1'b0, 1'b0, 16'h0300);
        step(1'b1, 16'h0399, 16'h9999, 2, 1'b1, 1'b0, 16'h0304);
        step(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 16'h0304);
        step(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, 16'h0303);
        repeat (2) step(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, 16'h0300);

        // 5: wrap with mem_ready toggling every cycle
        for (int i = 0; i < 50; i++) begin
            cc = legal_cc(2);
            step(i < 20, 16'(16'h0400 + i), 16'(16'hF000 + i * 7), cc, 1'b0, i[0], 16'(16'h0400 + i / 2));
        end

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cc = legal_cc(int'($urandom_range(0, 2)));
            sa = 16'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, 16'($urandom_range(0, 7)), 16'($urandom),
                 cc, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, sa);
        end

        // 6: reset asserted mid-drain
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'(16'h0500 + i), 16'(16'hAB00 + i), legal_cc(1), 1'b0, 1'b0, 16'h0500);
        step(1'b0, 16'h0000, 16'h0000, legal_cc(2), 1'b0, 1'b0, 16'h0500);
        @(negedge clk);
        mem_ready   = 1'b0;
        commit_cnt  = 2'd0;
        enq_valid   = 1'b0;
        search_addr = 16'h0500;
        #1;
        chk("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        mem_ready = 1'b1;
        enq_valid = 1'b1;
        @(posedge clk);
        #1;
        check_reset("held_rst");
        @(negedge clk);
        enq_valid = 1'b0;
        rst_n     = 1'b1;
        m_addr.delete();
        m_data.delete();
        m_ncmt = 0;
        repeat (2) step(1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, 16'h0500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
